// File: rtl/cluster_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cluster_mem_responder                                        |
// | Description : Single-transaction load/store responder between the hart     |
// |               cluster request port and a 128-bit line-oriented back end.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cluster_mem_responder #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic                CLK,
  input  logic                RST_X,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [2:0]          i_ctrl,
  input  logic                i_re,
  input  logic                i_we,
  input  logic [31:0]         i_wdata,
  output logic                o_busy,
  output logic                o_rvalid,
  output logic [31:0]         o_rdata,
  output logic [LINE_W-1:0]   o_line,
  output logic                m_req_valid,
  input  logic                m_req_ready,
  output logic                m_req_we,
  output logic [ADDR_W-5:0]   m_addr,
  output logic [LINE_W-1:0]   m_wdata,
  output logic [LINE_W/8-1:0] m_wmask,
  input  logic                m_rvalid,
  input  logic [LINE_W-1:0]   m_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_ctrl;
  logic [31:0]         r_wdata;
  logic                r_we;
  logic [31:0]         r_rdata;
  logic [LINE_W-1:0]   r_line;

  logic                w_req;
  logic [31:0]         w_word;
  logic [15:0]         w_half;
  logic [7:0]          w_byte;
  logic [31:0]         w_load;
  logic [LINE_W-1:0]   w_wdata;
  logic [LINE_W/8-1:0] w_wmask;

  assign w_req = i_re | i_we;

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_next = S_ISSUE;
      S_ISSUE: if (m_req_ready) w_next = r_we ? S_RESP : S_WAIT;
      S_WAIT:  if (m_rvalid) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request is latched once in IDLE; write wins when both strobes are high.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      r_addr  <= '0;
      r_ctrl  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
      r_line  <= '0;
    end else begin
      if (r_state == S_IDLE && w_req) begin
        r_addr  <= i_addr;
        r_ctrl  <= i_ctrl;
        r_wdata <= i_wdata;
        r_we    <= i_we;
      end
      if (r_state == S_WAIT && m_rvalid) begin
        r_line  <= m_rdata;
        r_rdata <= w_load;
      end
    end
  end

  assign w_word = m_rdata[{r_addr[3:2], 5'd0} +: 32];
  assign w_half = m_rdata[{r_addr[3:1], 4'd0} +: 16];
  assign w_byte = m_rdata[{r_addr[3:0], 3'd0} +: 8];

  always_comb begin
    w_load = w_word;
    case (r_ctrl)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = w_word;
    endcase
  end

  // Store data is replicated across every lane so the mask alone picks the target bytes.
  always_comb begin
    w_wdata = {(LINE_W/32){r_wdata}};
    w_wmask = (LINE_W/8)'(4'hF) << {r_addr[3:2], 2'b00};
    case (r_ctrl)
      3'b000: begin
        w_wdata = {(LINE_W/8){r_wdata[7:0]}};
        w_wmask = (LINE_W/8)'(1'b1) << r_addr[3:0];
      end
      3'b001: begin
        w_wdata = {(LINE_W/16){r_wdata[15:0]}};
        w_wmask = (LINE_W/8)'(2'b11) << {r_addr[3:1], 1'b0};
      end
      default: begin
        w_wdata = {(LINE_W/32){r_wdata}};
        w_wmask = (LINE_W/8)'(4'hF) << {r_addr[3:2], 2'b00};
      end
    endcase
  end

  assign m_req_valid = (r_state == S_ISSUE);
  assign m_req_we    = r_we;
  assign m_addr      = r_addr[ADDR_W-1:4];
  assign m_wdata     = w_wdata;
  assign m_wmask     = r_we ? w_wmask : '0;

  assign o_busy   = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_IDLE && w_req);
  assign o_rvalid = (r_state == S_RESP);
  assign o_rdata  = r_rdata;
  assign o_line   = r_line;

endmodule
`default_nettype wire

// File: tb/tb_cluster_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cluster_mem_responder                                     |
// | Description : Scoreboard bench with a behavioural back end and load/store  |
// |               reference model for cluster_mem_responder.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cluster_mem_responder;

  logic         CLK;
  logic         RST_X;
  logic [31:0]  i_addr;
  logic [2:0]   i_ctrl;
  logic         i_re;
  logic         i_we;
  logic [31:0]  i_wdata;
  logic         o_busy;
  logic         o_rvalid;
  logic [31:0]  o_rdata;
  logic [127:0] o_line;
  logic         m_req_valid;
  logic         m_req_ready;
  logic         m_req_we;
  logic [27:0]  m_addr;
  logic [127:0] m_wdata;
  logic [15:0]  m_wmask;
  logic         m_rvalid;
  logic [127:0] m_rdata;

  cluster_mem_responder #(.ADDR_W(32), .LINE_W(128)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .i_addr(i_addr), .i_ctrl(i_ctrl), .i_re(i_re), .i_we(i_we), .i_wdata(i_wdata),
    .o_busy(o_busy), .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_line(o_line),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct { logic [27:0] addr; logic we; logic [127:0] wdata; logic [15:0] wmask; } req_t;
  typedef struct { logic [31:0] rdata; logic [127:0] line; } rsp_t;

  req_t         req_q[$];
  rsp_t         rsp_q[$];
  logic [127:0] line_q[$];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, n_resp = 0, n_accept = 0, resp_cyc = 0;
  int be_stall = 0, be_rdelay = 0;
  logic [31:0]  mdl_rdata = '0;
  logic [127:0] mdl_line  = '0;
  bit           be_wr;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: access size and natural alignment inside the 16-byte line.
  function automatic int ld_size(input logic [2:0] c);
    case (c)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic int st_size(input logic [2:0] c);
    if (c == 3'd0) return 1;
    if (c == 3'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [127:0] ln, input logic [3:0] off, input logic [2:0] c);
    int sz = ld_size(c);
    int base = (int'(off) / sz) * sz;
    logic [63:0] v = '0;
    for (int i = 0; i < sz; i++) v = v | ({56'd0, ln[8*(base+i) +: 8]} << (8*i));
    if (c[2] == 1'b0 && sz < 4 && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
    return v[31:0];
  endfunction

  function automatic logic [127:0] ref_wdata(input logic [31:0] wd, input logic [2:0] c);
    int sz = st_size(c);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [15:0] ref_mask(input logic [3:0] off, input logic [2:0] c);
    int sz = st_size(c);
    int base = (int'(off) / sz) * sz;
    logic [15:0] m = '0;
    for (int i = 0; i < sz; i++) m[base+i] = 1'b1;
    return m;
  endfunction

  // Behavioural back end: ready after be_stall ISSUE cycles, line after be_rdelay WAIT cycles.
  initial begin
    m_req_ready = 1'b0;
    m_rvalid    = 1'b0;
    m_rdata     = '0;
    forever begin
      tick();
      m_req_ready = 1'b0;
      m_rvalid    = 1'b0;
      if (m_req_valid) begin
        repeat (be_stall) tick();
        m_req_ready = 1'b1;
        be_wr = m_req_we;
        tick();
        m_req_ready = 1'b0;
        if (!be_wr) begin
          repeat (be_rdelay) tick();
          m_rdata  = (line_q.size() > 0) ? line_q.pop_front() : {$urandom, $urandom, $urandom, $urandom};
          m_rvalid = 1'b1;
        end
      end
    end
  end

  // Monitor: request-side payload and response-side data against the scoreboard.
  always @(negedge CLK) begin
    if (RST_X) begin
      if (m_req_valid) begin
        chk("busy_in_issue", o_busy, 1);
        if (req_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL req_unexpected: got addr %h expected no request", m_addr);
        end else begin
          chk("m_addr", m_addr, req_q[0].addr);
          chk("m_req_we", m_req_we, req_q[0].we);
          chk("m_wmask", m_wmask, req_q[0].wmask);
          if (req_q[0].we) chk("m_wdata", m_wdata, req_q[0].wdata);
          if (m_req_ready) begin
            void'(req_q.pop_front());
            n_accept++;
          end
        end
      end
      if (o_rvalid) begin
        n_resp++;
        resp_cyc = cyc;
        chk("busy_in_resp", o_busy, 0);
        if (rsp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL rsp_unexpected: got rdata %h expected no response", o_rdata);
        end else begin
          chk("o_rdata", o_rdata, rsp_q[0].rdata);
          chk("o_line", o_line, rsp_q[0].line);
          void'(rsp_q.pop_front());
        end
      end
    end
  end

  task automatic push_txn(input logic [31:0] a, input logic [2:0] c, input logic we,
                          input logic [31:0] wd, input logic [127:0] ln);
    req_t rq;
    rsp_t rs;
    rq.addr  = a[31:4];
    rq.we    = we;
    rq.wdata = ref_wdata(wd, c);
    rq.wmask = we ? ref_mask(a[3:0], c) : 16'h0;
    req_q.push_back(rq);
    if (!we) begin
      line_q.push_back(ln);
      mdl_line  = ln;
      mdl_rdata = ref_load(ln, a[3:0], c);
    end
    rs.rdata = mdl_rdata;
    rs.line  = mdl_line;
    rsp_q.push_back(rs);
  endtask

  task automatic wait_resp(input int target, input bit scramble);
    for (int k = 0; k < 60 && n_resp < target; k++) begin
      if (scramble) begin
        i_addr  = $urandom;
        i_wdata = $urandom;
        i_ctrl  = 3'($urandom_range(0, 7));
      end
      tick();
    end
    if (n_resp < target) begin
      n_cmp++; n_fail++;
      $display("FAIL resp_timeout: got %0d responses expected %0d", n_resp, target);
    end
  endtask

  task automatic run_txn(input logic [31:0] a, input logic [2:0] c, input logic re, input logic we,
                         input logic [31:0] wd, input logic [127:0] ln, input int stall, input int rdelay);
    int c0, start, lat;
    push_txn(a, c, we, wd, ln);
    be_stall  = stall;
    be_rdelay = rdelay;
    i_addr = a; i_ctrl = c; i_wdata = wd; i_re = re; i_we = we;
    c0 = cyc;
    start = n_resp;
    #2 chk("busy_on_request", o_busy, 1);
    tick();
    i_re = 1'b0;
    i_we = 1'b0;
    wait_resp(start + 1, 1'b1);
    lat = stall + 2 + (we ? 0 : rdelay + 1);
    chk("latency", resp_cyc - c0, lat);
  endtask

  initial begin
    logic [127:0] ln;
    int start, a0, sel;
    RST_X = 1'b0; i_addr = '0; i_ctrl = '0; i_re = 1'b0; i_we = 1'b0; i_wdata = '0;
    repeat (3) tick();
    chk("rst_o_rvalid", o_rvalid, 0);
    chk("rst_o_rdata", o_rdata, 0);
    chk("rst_o_line", o_line, 0);
    chk("rst_m_req_valid", m_req_valid, 0);
    chk("rst_o_busy", o_busy, 0);
    RST_X = 1'b1;
    tick();

    run_txn(32'h8000_0014, 3'b010, 1, 0, 32'h0, 128'h00000000_00000000_DEADBEEF_00000000, 0, 0);
    ln = 128'h00000000_00000000_80010000_00000000;
    run_txn(32'h0000_2007, 3'b000, 1, 0, 32'h0, ln, 0, 0);
    run_txn(32'h0000_2007, 3'b100, 1, 0, 32'h0, ln, 1, 0);
    run_txn(32'h0000_2006, 3'b001, 1, 0, 32'h0, ln, 0, 2);
    run_txn(32'h1000_000A, 3'b001, 0, 1, 32'h1234_ABCD, '0, 0, 0);
    run_txn(32'h2000_0031, 3'b010, 1, 1, 32'hCAFE_F00D, '0, 5, 0);

    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 2);
      ln  = {$urandom, $urandom, $urandom, $urandom};
      run_txn($urandom, 3'($urandom_range(0, 7)), sel != 1, sel != 0, $urandom, ln,
              $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Back-to-back reads with i_re held: the second must start in the cycle after RESP.
    be_stall = 0; be_rdelay = 0;
    push_txn(32'h0000_0048, 3'b010, 0, 32'h0, {$urandom, $urandom, $urandom, $urandom});
    push_txn(32'h0000_0048, 3'b010, 0, 32'h0, {$urandom, $urandom, $urandom, $urandom});
    i_addr = 32'h0000_0048; i_ctrl = 3'b010; i_wdata = '0; i_re = 1'b1; i_we = 1'b0;
    start = n_resp;
    wait_resp(start + 1, 1'b0);
    #2;
    chk("b2b_busy_idle", o_busy, 1);
    chk("b2b_no_req_in_idle", m_req_valid, 0);
    tick();
    chk("b2b_second_issue", m_req_valid, 1);
    i_re = 1'b0;
    wait_resp(start + 2, 1'b0);
    repeat (4) tick();
    chk("b2b_resp_count", n_resp, start + 2);
    chk("b2b_req_drained", req_q.size(), 0);

    // Reset while waiting for the line; the late line must be ignored.
    be_stall = 0; be_rdelay = 2;
    push_txn(32'h0000_0100, 3'b010, 0, 32'h0, {$urandom, $urandom, $urandom, $urandom});
    void'(rsp_q.pop_back());
    a0 = n_accept;
    start = n_resp;
    i_addr = 32'h0000_0100; i_ctrl = 3'b010; i_re = 1'b1;
    tick();
    i_re = 1'b0;
    tick();
    chk("rst_test_accepted", n_accept, a0 + 1);
    chk("rst_test_busy_wait", o_busy, 1);
    RST_X = 1'b0;
    tick();
    RST_X = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("stale_o_rvalid", o_rvalid, 0);
      chk("stale_o_line", o_line, 0);
      chk("stale_m_req_valid", m_req_valid, 0);
      chk("stale_o_busy", o_busy, 0);
      tick();
    end
    chk("stale_resp_count", n_resp, start);
    chk("stale_o_rdata", o_rdata, 0);
    line_q.delete();
    mdl_rdata = '0;
    mdl_line  = '0;

    run_txn(32'h0000_0203, 3'b000, 1, 0, 32'h0, {$urandom, $urandom, $urandom, $urandom}, 1, 1);
    run_txn(32'h0000_020F, 3'b000, 0, 1, 32'h0000_005A, '0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/cluster_mem_responder.md
Name: cluster_mem_responder

Overview:
- Memory-side responder for the hart cluster's DRAM request port.
- Accepts one load or store per transaction: address, funct3 size code, read/write strobes and store data.
- Drives a 128-bit line-oriented memory back end, then returns busy, the extended load word and the raw line to the cluster.
- Sits between the cluster request mux and the DRAM controller; provides the busy/odata/line side that the cluster arbiter consumes.

Parameters:
- ADDR_W, 32, request address width (line address is ADDR_W-4 bits)
- LINE_W, 128, back-end line width in bits (fixed 128; 16 bytes)

Ports:
- CLK  in  1  clock
- RST_X  in  1  synchronous active-low reset
- i_addr  in  32  byte address of request
- i_ctrl  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_re  in  1  read request strobe (also covers insn fetch)
- i_we  in  1  write request strobe
- i_wdata  in  32  store data, LSB-aligned
- o_busy  out  1  request in progress; cluster must hold its request stable while high
- o_rvalid  out  1  one-cycle pulse: o_rdata/o_line valid
- o_rdata  out  32  load result, sign- or zero-extended per funct3
- o_line  out  128  full line from last completed read
- m_req_valid  out  1  back-end request valid
- m_req_ready  in  1  back-end accepts request
- m_req_we  out  1  1 = write, 0 = read
- m_addr  out  28  line address = latched addr[31:4]
- m_wdata  out  128  replicated store data
- m_wmask  out  16  byte enables for writes (0 for reads)
- m_rvalid  in  1  read line return
- m_rdata  in  128  returned line

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset (RST_X=0 at posedge): state=IDLE, m_req_valid=0, o_rvalid=0, o_rdata=0, o_line=0, latched request cleared. Reset mid-transaction aborts it. An m_rvalid arriving after reset, while in IDLE, is ignored.
- IDLE: if i_we or i_re, latch addr/ctrl/wdata/we and go to ISSUE. i_we has priority when both are high; the transaction is then a write only.
- ISSUE: m_req_valid=1 with stable m_addr/m_req_we/m_wdata/m_wmask until m_req_ready is sampled high.
  - On that edge: read -> WAIT; write -> RESP.
  - If m_rvalid coincides with acceptance, it is not captured. The back end must not return data in its accept cycle.
- WAIT: on m_rvalid, capture m_rdata into o_line, compute o_rdata, go to RESP.
- RESP: o_rvalid=1 for exactly one cycle, then IDLE. New requests are not accepted in RESP. o_rvalid also pulses after writes; o_rdata/o_line are unchanged by writes.
- o_busy = (state==ISSUE || state==WAIT) || (state==IDLE && (i_re || i_we)).
  - Combinational, so busy is visible in the acceptance cycle.
  - Low in RESP and in idle IDLE.
- Minimum latency: read 3 cycles (accept, ISSUE with ready=1, WAIT with rvalid=1) then RESP. Write: accept, ISSUE, then RESP.
- Lane selection by latched offset addr[3:0]:
  - W/other: word lane addr[3:2]; addr[1:0] ignored.
  - H/HU: halfword lane addr[3:1]; addr[0] ignored.
  - B/BU: byte lane addr[3:0].
- Load extension: 000 sign-extend byte; 001 sign-extend half; 100/101 zero-extend; 010, 011, 110, 111 return the full word.
- Store data: m_wdata = 16x byte (SB), 8x half (SH), 4x word (SW and all other codes).
- Store mask (one-hot lane):
  - SB: bit addr[3:0].
  - SH: 2'b11 << (2*addr[3:1]).
  - SW/others: 4'hF << (4*addr[3:2]).
- No cross-line accesses: offsets are truncated as above, and accesses never wrap into the next line.
- Request inputs changing while busy are ignored; only latched values drive the back end.

Test Plan:
- LW at 0x8000_0014, m_rdata word1=0xDEAD_BEEF, ready and rvalid immediate -> m_addr=0x800_0001, o_rdata=0xDEADBEEF, o_rvalid pulses in cycle 4, o_busy high cycles 1-3.
- LB/LBU at offset 0x7 with byte 0x80 -> LB o_rdata=0xFFFF_FF80, LBU o_rdata=0x0000_0080; LH at offset 0x6 with half 0x8001 -> 0xFFFF_8001.
- SH at 0x1000_000A, wdata=0x1234ABCD -> m_req_we=1, m_wmask=0x0C00, m_wdata=8x 0xABCD; o_line/o_rdata unchanged; o_rvalid pulse after ready.
- i_re and i_we both high, m_req_ready held low 5 cycles -> write issued; m_req_valid and payload stable for all 5 cycles; o_busy high throughout; accepted on cycle 6.
- Reset asserted in WAIT, then stale m_rvalid=1 after release -> state IDLE, o_rvalid stays 0, o_line stays 0.
- Back-to-back reads with i_re held -> second request accepted in the cycle after RESP; exactly one o_rvalid pulse per transaction.
